// File: rtl/sym_pack_pkg.sv
// Shared widths and lane-count type for the 10-bit symbol to 80-bit word packer.
package sym_pack_pkg;
  localparam int SYM_W  = 10;
  localparam int SYMS   = 8;
  localparam int WORD_W = SYM_W * SYMS;
  localparam int LANE_W = $clog2(SYMS);

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(SYMS - 1);
endpackage

// File: rtl/sym_parity_chk.sv
// Combinational odd-parity check of one symbol: err is set when [8:0] has even weight.
import sym_pack_pkg::*;

module sym_parity_chk (
  input  logic [SYM_W-1:0] sym,
  output logic             err
);
  // Bit 9 is a pass-through tag and takes no part in parity.
  logic unused_tag;
  assign unused_tag = sym[9];
  assign err        = ~^sym[8:0];
endmodule

// File: rtl/sym_pack_80.sv
// Packs eight 10-bit symbols into one lane-aligned 80-bit word, with SOF resync.
// Optional per-symbol parity accumulation when SYM_PARITY_CHK_EN is defined.
import sym_pack_pkg::*;

module sym_pack_80 (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_err,
  output logic              sof_slip
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and in_ready depends combinationally on out_ready.
  lane_t             cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sof_slip_q, sof_slip_d;

  logic accept, sof_acc, complete;

  // Only the completing lane can stall; earlier lanes never touch the output register.
  assign in_ready = (cnt_q != LAST_LANE) || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign sof_acc  = accept && in_sof;
  assign complete = accept && !in_sof && (cnt_q == LAST_LANE);

  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sof_slip_d  = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (sof_acc) begin
      asm_d[SYM_W-1:0] = in_sym;
      cnt_d            = lane_t'(1);
      sof_slip_d       = (cnt_q != '0);
    end else if (accept) begin
      asm_d[int'(cnt_q)*SYM_W +: SYM_W] = in_sym;
      if (complete) begin
        out_data_d  = asm_d;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + lane_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sof_slip_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sof_slip_q  <= sof_slip_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sof_slip  = sof_slip_q;

`ifdef SYM_PARITY_CHK_EN
  logic sym_err;
  logic perr_q, perr_d;
  logic out_err_q, out_err_d;

  sym_parity_chk u_parity (
    .sym (in_sym),
    .err (sym_err)
  );

  // Sticky error restarts on SOF and wrap; the completing lane joins the loaded flag.
  always_comb begin
    perr_d    = perr_q;
    out_err_d = out_err_q;
    if (sof_acc) begin
      perr_d = sym_err;
    end else if (complete) begin
      perr_d    = 1'b0;
      out_err_d = perr_q | sym_err;
    end else if (accept) begin
      perr_d = perr_q | sym_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q    <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_sym_pack_80.sv
// Directed bench for sym_pack_80: reset, packing, streaming, stall, SOF resync, parity, reset mid-word.
module tb_sym_pack_80;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_sym;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;
  logic        out_err;
  logic        sof_slip;

  int pass_cnt = 0;
  int total    = 0;
  logic [79:0] exp_q[$];

  sym_pack_80 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .sof_slip  (sof_slip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Good odd parity over [8:0]: bit 8 makes the weight of [8:0] odd.
  function automatic logic [9:0] good_sym(input logic tag, input logic [7:0] v);
    return {tag, ~^v, v};
  endfunction

  // Drive one symbol at the negedge, record in_ready, return #1 after the edge.
  task automatic send(input logic [9:0] s, input logic sof, output logic acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = s;
    in_sof   = sof;
    #1 acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sym = '0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 80'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
    total++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else pass_cnt++;
    total++; if (sof_slip !== 1'b0) $display("FAIL reset_sof_slip got %b want 0", sof_slip); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic acc;
    logic [79:0] exp_w;
    exp_w = {10'h107, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 10'h100};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(10'h100 + 10'(i), 1'b0, acc);
      if (i == 6) begin
        total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else pass_cnt++;
      end
    end
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else pass_cnt++;
    total++; if (out_data !== exp_w) $display("FAIL basic_data got %h want %h", out_data, exp_w); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [79:0] w;
    logic [9:0]  s;
    int ready_low = 0;
    int words     = 0;
    out_ready = 1'b1;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      s = 10'($urandom_range(0, 1023));
      w[(i % 8)*10 +: 10] = s;
      send(s, 1'b0, acc);
      if (acc !== 1'b1) ready_low++;
      if ((i % 8) == 7) begin
        exp_q.push_back(w);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0])
          $display("FAIL stream_word%0d got v=%b %h want v=1 %h", i / 8, out_valid, out_data, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
        words++;
      end
    end
    total++; if (ready_low !== 0) $display("FAIL stream_in_ready_low got %0d want 0", ready_low); else pass_cnt++;
    total++; if (words !== 8) $display("FAIL stream_words got %0d want 8", words); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic acc;
    logic [79:0] wa, wb;
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wa[i*10 +: 10] = 10'h200 + 10'(i);
      send(10'h200 + 10'(i), 1'b0, acc);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wb[i*10 +: 10] = 10'h010 + 10'(i);
      send(10'h010 + 10'(i), 1'b0, acc);
      if (acc !== 1'b1 || out_valid !== 1'b1 || out_data !== wa) bad++;
    end
    total++; if (bad !== 0) $display("FAIL stall_lanes_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    wb[79:70] = 10'h3aa;
    @(negedge clk);
    in_valid = 1'b1; in_sym = 10'h3aa; in_sof = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (out_data !== wa || out_valid !== 1'b1) $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, out_data, wa); else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== wb) $display("FAIL stall_next_word got v=%b %h want v=1 %h", out_valid, out_data, wb); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_sof();
    logic acc;
    logic [79:0] w;
    int pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(10'h0f0 + 10'(i), 1'b0, acc);
    send(10'h155, 1'b1, acc);
    w[9:0] = 10'h155;
    total++; if (sof_slip !== 1'b1) $display("FAIL sof_slip_pulse got %b want 1", sof_slip); else pass_cnt++;
    for (int i = 1; i < 8; i++) begin
      w[i*10 +: 10] = 10'h060 + 10'(i);
      send(10'h060 + 10'(i), 1'b0, acc);
      if (sof_slip === 1'b1) pulses++;
      if (i == 6) begin
        total++; if (out_valid !== 1'b0) $display("FAIL sof_early_valid got %b want 0", out_valid); else pass_cnt++;
      end
    end
    total++; if (pulses !== 0) $display("FAIL sof_extra_pulses got %0d want 0", pulses); else pass_cnt++;
    total++; if (out_valid !== 1'b1 || out_data !== w) $display("FAIL sof_word got v=%b %h want v=1 %h", out_valid, out_data, w); else pass_cnt++;
    // SOF on an aligned boundary is an ordinary accept.
    send(10'h2c3, 1'b1, acc);
    total++; if (sof_slip !== 1'b0) $display("FAIL sof_aligned_pulse got %b want 0", sof_slip); else pass_cnt++;
    for (int i = 1; i < 8; i++) send(10'h040 + 10'(i), 1'b0, acc);
    total++; if (out_valid !== 1'b1 || out_data[9:0] !== 10'h2c3) $display("FAIL sof_aligned_word got v=%b %h want v=1 lane0 2c3", out_valid, out_data[9:0]); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_parity();
    logic acc;
    logic exp_err;
`ifdef SYM_PARITY_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send((i == 5) ? 10'h000 : good_sym(i[0], 8'(8'h31 + i)), 1'b0, acc);
    total++; if (out_err !== exp_err || out_valid !== 1'b1) $display("FAIL parity_bad_word got err=%b v=%b want err=%b v=1", out_err, out_valid, exp_err); else pass_cnt++;
    for (int i = 0; i < 8; i++) send(good_sym(1'b1, 8'(8'h90 + 3*i)), 1'b0, acc);
    total++; if (out_err !== 1'b0 || out_valid !== 1'b1) $display("FAIL parity_clean_word got err=%b v=%b want err=0 v=1", out_err, out_valid); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midword();
    logic acc;
    logic [79:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(10'h111, 1'b0, acc);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(10'h0aa + 10'(i), 1'b0, acc);
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (dut.cnt_q !== 3'd0) $display("FAIL rstmid_cnt got %0d want 0", dut.cnt_q); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w[i*10 +: 10] = 10'h300 + 10'(i*5);
      send(10'h300 + 10'(i*5), 1'b0, acc);
    end
    total++; if (out_valid !== 1'b1 || out_data !== w) $display("FAIL rstmid_clean_word got v=%b %h want v=1 %h", out_valid, out_data, w); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_sof();
    test_parity();
    test_reset_midword();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
